// File: rtl/code5421_pkg.sv
`default_nettype none
// ============================================================================
// code5421_pkg : shared 5421-code constants, invalid test, FSM state, widths
// Rev 1.0
// ============================================================================
package code5421_pkg;

  localparam int ERR_CNT_W = 8;

  localparam logic [3:0] C5421_0 = 4'b0000;
  localparam logic [3:0] C5421_1 = 4'b0001;
  localparam logic [3:0] C5421_2 = 4'b0010;
  localparam logic [3:0] C5421_3 = 4'b0011;
  localparam logic [3:0] C5421_4 = 4'b0100;
  localparam logic [3:0] C5421_5 = 4'b1000;
  localparam logic [3:0] C5421_6 = 4'b1001;
  localparam logic [3:0] C5421_7 = 4'b1010;
  localparam logic [3:0] C5421_8 = 4'b1011;
  localparam logic [3:0] C5421_9 = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // The 4-weight bit can only stand alone: x1xx with either low bit set is illegal.
  function automatic logic is_invalid_5421(input logic [3:0] code);
    return code[2] && (code[1] || code[0]);
  endfunction

endpackage : code5421_pkg
`default_nettype wire

// File: rtl/dec_digit_5421.sv
`default_nettype none
// ============================================================================
// dec_digit_5421 : combinational single-digit 5421 -> BCD decoder
// Rev 1.0
// ============================================================================
module dec_digit_5421
  import code5421_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] bcd_o,
  output logic       invalid_o
);

  always_comb begin
    invalid_o = is_invalid_5421(code_i);
    case (code_i)
      C5421_0: bcd_o = 4'd0;
      C5421_1: bcd_o = 4'd1;
      C5421_2: bcd_o = 4'd2;
      C5421_3: bcd_o = 4'd3;
      C5421_4: bcd_o = 4'd4;
      C5421_5: bcd_o = 4'd5;
      C5421_6: bcd_o = 4'd6;
      C5421_7: bcd_o = 4'd7;
      C5421_8: bcd_o = 4'd8;
      C5421_9: bcd_o = 4'd9;
      default: bcd_o = 4'd0;
    endcase
  end

endmodule : dec_digit_5421
`default_nettype wire

// File: rtl/code5421_to_bcd_decoder.sv
`default_nettype none
// ============================================================================
// code5421_to_bcd_decoder : digit-serial packed 5421 -> packed BCD decoder
// Rev 1.0
// ============================================================================
module code5421_to_bcd_decoder
  import code5421_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  input  logic                  clr_err
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e                 state_q, state_d;
  logic [4*DIGITS-1:0]    code_q;
  logic [4*DIGITS-1:0]    bcd_q;
  logic [DIGITS-1:0]      err_q;
  logic [IDX_W-1:0]       idx_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [3:0]             digit_code;
  logic [3:0]             digit_bcd;
  logic                   digit_inv;
  logic                   accept;
  logic                   decoding;
  logic                   last_digit;
  logic                   word_bad;

  assign accept     = in_valid && (state_q == IDLE);
  assign decoding   = (state_q == DECODE);
  assign last_digit = decoding && (idx_q == LAST_IDX);
  assign digit_code = code_q[{idx_q, 2'b00} +: 4];
  // Digit being decoded this cycle is not yet in err_q, so OR it in.
  assign word_bad   = (|err_q) || digit_inv;

  dec_digit_5421 u_dec (
    .code_i    (digit_code),
    .bcd_o     (digit_bcd),
    .invalid_o (digit_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = DECODE;
      DECODE:  if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_bcd   = bcd_q;
    out_err   = err_q;
    err_count = err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      bcd_q  <= '0;
      err_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      code_q <= in_code;
      bcd_q  <= '0;
      err_q  <= '0;
      idx_q  <= '0;
    end else if (decoding) begin
      bcd_q[{idx_q, 2'b00} +: 4] <= digit_bcd;
      err_q[idx_q]               <= digit_inv;
      idx_q                      <= last_digit ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (last_digit && word_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule : code5421_to_bcd_decoder
`default_nettype wire
